// File: rtl/bus_pkg.sv
// Shared bus-arbitration types.
//   arb_state_t  : arbiter FSM state
//   MSEL_*       : master_sel encodings, also used by the bus mux
//   last_grant_t : which initiator won the most recent initiator grant
package bus_pkg;
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GNT_I1    = 2'd1,
    ST_GNT_I2    = 2'd2,
    ST_GNT_SPLIT = 2'd3
  } arb_state_t;

  localparam logic [1:0] MSEL_NONE  = 2'd0;
  localparam logic [1:0] MSEL_I1    = 2'd1;
  localparam logic [1:0] MSEL_I2    = 2'd2;
  localparam logic [1:0] MSEL_SPLIT = 2'd3;

  typedef enum logic {
    LAST_I1 = 1'b0,
    LAST_I2 = 1'b1
  } last_grant_t;
endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter handshake bundle.
//   master : requester side (drives requests / split handshake, sees grants)
//   slave  : arbiter side (sees requests, drives grants and status)
interface bus_arbiter_if;
  logic       init1_req;
  logic       init2_req;
  logic       split_req;
  logic       split_ack;
  logic       init1_grant;
  logic       init2_grant;
  logic       split_grant;
  logic [1:0] master_sel;
  logic       split_pending;
  logic [1:0] split_owner;
  logic       protocol_err;

  modport master (
    output init1_req, init2_req, split_req, split_ack,
    input  init1_grant, init2_grant, split_grant, master_sel,
           split_pending, split_owner, protocol_err
  );

  modport slave (
    input  init1_req, init2_req, split_req, split_ack,
    output init1_grant, init2_grant, split_grant, master_sel,
           split_pending, split_owner, protocol_err
  );
endinterface

// File: rtl/arb_rr_pick.sv
// Two-way round-robin selector (combinational).
//   elig1_i/elig2_i : initiator eligibilities
//   last_i          : initiator granted most recently
//   valid_o         : some initiator is eligible
//   pick_i2_o       : 1 = pick init2, 0 = pick init1 (meaningful when valid_o)
module arb_rr_pick
  import bus_pkg::*;
(
  input  logic        elig1_i,
  input  logic        elig2_i,
  input  last_grant_t last_i,
  output logic        valid_o,
  output logic        pick_i2_o
);
  always_comb begin
    valid_o = elig1_i | elig2_i;
    // On contention the initiator not served last wins.
    if (elig1_i && elig2_i) pick_i2_o = (last_i == LAST_I1);
    else                    pick_i2_o = elig2_i;
  end
endmodule

// File: rtl/bus_arbiter.sv
// Bus arbiter for two initiators plus a split target returning deferred data.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : bus_arbiter_if.slave (requests in; grants, master_sel,
//                split_pending, split_owner, protocol_err out)
//   SPLIT_FIRST: 1 = split target beats initiators in IDLE, 0 = initiators first
// Grants decode straight from the state register, so they are registered and
// one-hot-or-zero by construction.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter bit SPLIT_FIRST = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  bus_arbiter_if.slave bus
);
  arb_state_t  state_q, state_d;
  last_grant_t last_q, last_d;
  logic        pend_q, pend_d;
  logic [1:0]  owner_q, owner_d;
  // Split owner masked for the single IDLE cycle after its split completes.
  logic [1:0]  mask_q, mask_d;
  logic        err_q, err_d;

  logic elig1, elig2, elig_split, pick_vld, pick_i2, in_gnt_i, cur_req;

  always_comb begin
    elig1      = bus.init1_req && !(pend_q && owner_q == MSEL_I1) && (mask_q != MSEL_I1);
    elig2      = bus.init2_req && !(pend_q && owner_q == MSEL_I2) && (mask_q != MSEL_I2);
    elig_split = bus.split_req && pend_q;
    in_gnt_i   = (state_q == ST_GNT_I1) || (state_q == ST_GNT_I2);
    cur_req    = (state_q == ST_GNT_I1) ? bus.init1_req : bus.init2_req;
  end

  arb_rr_pick u_pick (
    .elig1_i   (elig1),
    .elig2_i   (elig2),
    .last_i    (last_q),
    .valid_o   (pick_vld),
    .pick_i2_o (pick_i2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= LAST_I2;
      pend_q  <= 1'b0;
      owner_q <= MSEL_NONE;
      mask_q  <= MSEL_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      owner_q <= owner_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pend_d  = pend_q;
    owner_d = owner_q;
    mask_d  = MSEL_NONE;
    // Illegal split handshakes are ignored for control but recorded.
    err_d   = err_q | (bus.split_req & ~pend_q) | (bus.split_ack & (pend_q | ~in_gnt_i));
    case (state_q)
      ST_IDLE: begin
        if (elig_split && (SPLIT_FIRST || !pick_vld)) begin
          state_d = ST_GNT_SPLIT;  // split grants leave last_q alone
        end else if (pick_vld) begin
          state_d = pick_i2 ? ST_GNT_I2 : ST_GNT_I1;
          last_d  = pick_i2 ? LAST_I2 : LAST_I1;
        end
      end
      ST_GNT_I1, ST_GNT_I2: begin
        if (bus.split_ack && !pend_q) begin
          state_d = ST_IDLE;
          pend_d  = 1'b1;
          owner_d = (state_q == ST_GNT_I1) ? MSEL_I1 : MSEL_I2;
        end else if (!cur_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_GNT_SPLIT: begin
        if (!bus.split_req) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
          owner_d = MSEL_NONE;
          mask_d  = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [1:0] msel;
  always_comb begin
    case (state_q)
      ST_GNT_I1:    msel = MSEL_I1;
      ST_GNT_I2:    msel = MSEL_I2;
      ST_GNT_SPLIT: msel = MSEL_SPLIT;
      default:      msel = MSEL_NONE;
    endcase
  end

  assign bus.init1_grant   = (state_q == ST_GNT_I1);
  assign bus.init2_grant   = (state_q == ST_GNT_I2);
  assign bus.split_grant   = (state_q == ST_GNT_SPLIT);
  assign bus.master_sel    = msel;
  assign bus.split_pending = pend_q;
  assign bus.split_owner   = owner_q;
  assign bus.protocol_err  = err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized + directed bench for bus_arbiter. Two DUTs (SPLIT_FIRST=1 and 0)
// share the same request inputs; each is checked every cycle against an
// owner-based reference model.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic r1, r2, sr, sa;
  bit   cmp_en;
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  bus_arbiter_if bi1 ();
  bus_arbiter_if bi0 ();
  assign bi1.init1_req = r1; assign bi1.init2_req = r2;
  assign bi1.split_req = sr; assign bi1.split_ack = sa;
  assign bi0.init1_req = r1; assign bi0.init2_req = r2;
  assign bi0.split_req = sr; assign bi0.split_ack = sa;

  bus_arbiter #(.SPLIT_FIRST(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bi1.slave));
  bus_arbiter #(.SPLIT_FIRST(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bi0.slave));

  // Model: own = current bus owner (0 none, 1 init1, 2 init2, 3 split target).
  typedef struct {
    int own; bit pend; int powner; int last; bit err; int mask;
  } m_t;
  m_t mdl [2];

  function automatic m_t m_reset();
    m_t m;
    m.own = 0; m.pend = 0; m.powner = 0; m.last = 2; m.err = 0; m.mask = 0;
    return m;
  endfunction

  function automatic m_t m_step(m_t m, bit sf);
    m_t n = m;
    bit e1, e2, es;
    int win;
    n.mask = 0;
    if (sr && !m.pend) n.err = 1;
    if (sa && (m.pend || !(m.own == 1 || m.own == 2))) n.err = 1;
    if (m.own == 0) begin
      e1 = r1 && !(m.pend && m.powner == 1) && m.mask != 1;
      e2 = r2 && !(m.pend && m.powner == 2) && m.mask != 2;
      es = sr && m.pend;
      if (e1 && e2) win = (m.last == 1) ? 2 : 1;
      else          win = e1 ? 1 : (e2 ? 2 : 0);
      if (es && (sf || win == 0)) n.own = 3;
      else if (win != 0) begin n.own = win; n.last = win; end
    end else if (m.own == 3) begin
      if (!sr) begin n.own = 0; n.pend = 0; n.powner = 0; n.mask = m.powner; end
    end else begin
      if (sa && !m.pend) begin n.own = 0; n.pend = 1; n.powner = m.own; end
      else if (!((m.own == 1) ? r1 : r2)) n.own = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl[0] <= m_reset(); mdl[1] <= m_reset();
    end else begin
      mdl[0] <= m_step(mdl[0], 1'b0);
      mdl[1] <= m_step(mdl[1], 1'b1);
    end
  end

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask

  task automatic cmp_dut(string tag, int k, logic g1, logic g2, logic gs,
                         logic [1:0] ms, logic sp, logic [1:0] so, logic er);
    m_t m = mdl[k];
    int eg = (m.own == 1 ? 1 : 0) | (m.own == 2 ? 2 : 0) | (m.own == 3 ? 4 : 0);
    chk({tag, "_grants"}, {29'd0, gs, g2, g1}, eg);
    chk({tag, "_msel"}, int'(ms), m.own);
    chk({tag, "_pend"}, int'(sp), int'(m.pend));
    chk({tag, "_owner"}, int'(so), m.powner);
    chk({tag, "_err"}, int'(er), int'(m.err));
  endtask

  always @(negedge clk) if (cmp_en) begin
    cmp_dut("sf1", 1, bi1.init1_grant, bi1.init2_grant, bi1.split_grant,
            bi1.master_sel, bi1.split_pending, bi1.split_owner, bi1.protocol_err);
    cmp_dut("sf0", 0, bi0.init1_grant, bi0.init2_grant, bi0.split_grant,
            bi0.master_sel, bi0.split_pending, bi0.split_owner, bi0.protocol_err);
  end

  // Leaves the caller just after a negedge with reset released; the next
  // rising edge is the first active one.
  task automatic do_reset();
    @(negedge clk); #1;
    r1 = 0; r2 = 0; sr = 0; sa = 0; rst_n = 0;
    @(negedge clk); @(negedge clk); #1 rst_n = 1;
  endtask

  function automatic int grants1();
    return {29'd0, bi1.split_grant, bi1.init2_grant, bi1.init1_grant};
  endfunction

  initial begin
    r1 = 0; r2 = 0; sr = 0; sa = 0; rst_n = 1; cmp_en = 0;
    #3 rst_n = 0;
    @(negedge clk);
    cmp_en = 1;
    chk("rst_grants", grants1(), 0);
    chk("rst_msel", int'(bi1.master_sel), 0);
    chk("rst_err", int'(bi1.protocol_err), 0);

    // Single request held 6 cycles: grant for exactly 6 cycles, then drop.
    do_reset();
    r1 = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("d1_g1", int'(bi1.init1_grant), 1);
      chk("d1_msel", int'(bi1.master_sel), 1);
    end
    #1 r1 = 0;
    @(negedge clk);
    chk("d1_drop", grants1(), 0);
    chk("d1_msel0", int'(bi1.master_sel), 0);

    // Round-robin alternation with a turnaround cycle between grants.
    do_reset();
    r1 = 1; r2 = 1;
    @(negedge clk); chk("rr_first_i1", grants1(), 1);
    #1 r1 = 0;
    @(negedge clk); chk("rr_turn1", grants1(), 0);
    #1 r1 = 1;
    @(negedge clk); chk("rr_then_i2", grants1(), 2);
    #1 r2 = 0;
    @(negedge clk); chk("rr_turn2", grants1(), 0);
    #1 r2 = 1;
    @(negedge clk); chk("rr_back_i1", grants1(), 1);

    // Split deferral, owner masking, SPLIT_FIRST priority.
    do_reset();
    r1 = 1;
    @(negedge clk); chk("sp_g1", grants1(), 1);
    #1 sa = 1;
    @(negedge clk);
    chk("sp_drop", grants1(), 0);
    chk("sp_pend", int'(bi1.split_pending), 1);
    chk("sp_owner", int'(bi1.split_owner), 1);
    #1 sa = 0; r2 = 1;
    @(negedge clk); chk("sp_i2_while_i1_held", grants1(), 2);
    #1 r2 = 0;
    @(negedge clk); chk("sp_i1_masked", grants1(), 0);
    #1 sr = 1; r2 = 1;
    @(negedge clk);
    chk("sf1_split_first", grants1(), 4);
    chk("sf1_msel3", int'(bi1.master_sel), 3);
    chk("sf0_i2_first", int'(bi0.init2_grant), 1);
    chk("sf0_msel2", int'(bi0.master_sel), 2);
    #1 sr = 0; r2 = 0;
    @(negedge clk);
    chk("sp_done_pend", int'(bi1.split_pending), 0);
    chk("sp_done_owner", int'(bi1.split_owner), 0);
    @(negedge clk); chk("sp_post_mask", grants1(), 0);
    @(negedge clk); chk("sp_owner_regrant", grants1(), 1);

    // Split request with nothing pending: sticky error, no grant.
    do_reset();
    sr = 1;
    @(negedge clk);
    chk("err_set", int'(bi1.protocol_err), 1);
    chk("err_nogrant", grants1(), 0);
    #1 sr = 0;
    repeat (3) @(negedge clk);
    chk("err_sticky", int'(bi1.protocol_err), 1);

    // Asynchronous reset during a split grant.
    do_reset();
    r1 = 1;
    @(negedge clk); #1 sa = 1;
    @(negedge clk); #1 begin sa = 0; sr = 1; end
    @(negedge clk); chk("ar_split_gnt", grants1(), 4);
    #2 rst_n = 0;
    #1;
    chk("ar_grants", grants1(), 0);
    chk("ar_msel", int'(bi1.master_sel), 0);
    chk("ar_pend", int'(bi1.split_pending), 0);
    chk("ar_owner", int'(bi1.split_owner), 0);
    sr = 0;
    @(negedge clk); @(negedge clk); #1 rst_n = 1;
    @(negedge clk); chk("ar_regrant_i1", grants1(), 1);

    // Randomized traffic driven from the SPLIT_FIRST=1 model's view.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 599) == 0) rst_n = 0;
      if (!r1) r1 = ($urandom_range(0, 2) == 0);
      else if (mdl[1].own == 1 && $urandom_range(0, 3) == 0) r1 = 0;
      if (!r2) r2 = ($urandom_range(0, 2) == 0);
      else if (mdl[1].own == 2 && $urandom_range(0, 3) == 0) r2 = 0;
      sa = 0;
      if ((mdl[1].own == 1 || mdl[1].own == 2) && !mdl[1].pend && $urandom_range(0, 7) == 0) sa = 1;
      if ($urandom_range(0, 299) == 0) sa = 1;
      if (!sr) sr = mdl[1].pend && ($urandom_range(0, 3) == 0);
      else if (!mdl[1].pend || (mdl[1].own == 3 && $urandom_range(0, 2) == 0)) sr = 0;
    end
    @(negedge clk);
    cmp_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter SPLIT_FIRST, default 1: 1 = split_req beats initiator requests in IDLE; 0 = split_req granted only when no eligible initiator request.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 init1_req  in  1  initiator 1 bus request, held until its transaction completes.
REQ-005 init2_req  in  1  initiator 2 bus request, same rules.
REQ-006 split_req  in  1  split target requests bus to return deferred read data.
REQ-007 split_ack  in  1  split target single-cycle pulse: current transaction deferred.
REQ-008 init1_grant / init2_grant / split_grant  out  1 each  registered, one-hot-or-zero grants.
REQ-009 master_sel  out  2  encoded owner: 0 none, 1 init1, 2 init2, 3 split target.
REQ-010 split_pending  out  1  a split transaction is outstanding.
REQ-011 split_owner  out  2  initiator owning the outstanding split (1 or 2; 0 when none).
REQ-012 protocol_err  out  1  sticky protocol-violation flag.

Function
REQ-013 States: IDLE, GNT_I1, GNT_I2, GNT_SPLIT; grants and master_sel decode directly from state register.
REQ-014 IDLE: request sampled at edge t; grant high from t+1.
REQ-015 Eligible initiator: req high and not split_owner while split_pending; split_req eligible only when split_pending=1.
REQ-016 Both initiators eligible: grant the one not granted last (round-robin); last_grant reset to init2 so init1 wins first.
REQ-017 split_req vs initiator in IDLE resolved per SPLIT_FIRST; split grants do not update last_grant.
REQ-018 GNT_In: stay while initn_req high; req low at edge t -> IDLE at t+1 (grant low), next grant earliest t+2 (one turnaround cycle).
REQ-019 GNT_In with split_ack and split_pending=0: -> IDLE next edge, split_pending=1, split_owner=n; owner's req ignored until split completes.
REQ-020 GNT_SPLIT: hold while split_req high; split_req low -> IDLE, clear split_pending and split_owner same edge.
REQ-021 Owner masked additionally in the IDLE cycle following GNT_SPLIT; thereafter eligible normally if req still high.
REQ-022 split_ack with split_pending=1, split_ack outside GNT_In, or split_req with split_pending=0: ignored, protocol_err set.
REQ-023 No preemption: an active grant is never removed except by REQ-018, REQ-019, REQ-020.
REQ-024 At most one grant high at any cycle; master_sel always consistent with grants.

Reset
REQ-025 rst_n low asynchronously forces IDLE, all grants 0, master_sel 0, split_pending 0, split_owner 0, protocol_err 0, last_grant = init2.
REQ-026 Reset mid-transaction or mid-split discards all state; first grant after release follows REQ-014 with no stale split masking.

Structure
REQ-027 Package bus_pkg holds arb_state_t enum and master_sel encodings (MSEL_NONE, MSEL_I1, MSEL_I2, MSEL_SPLIT) shared with the bus mux.
REQ-028 One sub-module, arb_rr_pick: combinational two-way round-robin selector given eligibilities and last_grant; FSM and split tracking remain in bus_arbiter.

Verification
REQ-029 init1_req high at cycle 10, held 6 cycles -> init1_grant high cycles 11-16, low 17, master_sel=1 during grant.
REQ-030 init1_req and init2_req both high from reset release -> init1 granted first; after init1 drops, init2 granted after one idle cycle; repeat -> order alternates.
REQ-031 init1 granted, split_ack pulse -> grant drops next cycle, split_pending=1, split_owner=1; init2_req then granted while init1_req stays high and ungranted.
REQ-032 split pending, split_req and init2_req rise same cycle, SPLIT_FIRST=1 -> split_grant first, master_sel=3; SPLIT_FIRST=0 -> init2 first.
REQ-033 split_req with no pending split -> no grant, protocol_err=1 and stays 1 until reset.
REQ-034 rst_n asserted during GNT_SPLIT -> all outputs zero immediately (asynchronous); after release, init1_req granted in one cycle.
